// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 character-LCD controller.
// Holds the state encoding, the fixed power-on command list and helper math.
package lcd_pkg;

  typedef enum logic [2:0] {
    PWR_WAIT,
    INIT_LOAD,
    SETUP,
    PULSE,
    HOLD,
    WAIT,
    IDLE
  } state_t;

  typedef enum logic [1:0] {
    W_EXEC,
    W_CLEAR,
    W_LONG,
    W_SHORT
  } wait_sel_t;

  typedef struct packed {
    logic [7:0] data;
    wait_sel_t  sel;
  } init_step_t;

  localparam logic [7:0] CMD_CLEAR           = 8'h01;
  localparam logic [7:0] CMD_HOME            = 8'h02;
  localparam logic [7:0] CMD_HOME_ALT        = 8'h03;
  localparam logic [7:0] FUNC_SET_8BIT_2LINE = 8'h38;
  localparam logic [7:0] DISP_ON             = 8'h0C;
  localparam logic [7:0] ENTRY_INC           = 8'h06;

  localparam int INIT_STEPS = 7;

  // The repeated function-set writes are the HD44780 "reset by instruction" ritual.
  localparam init_step_t INIT_ROM [INIT_STEPS] = '{
    '{data: FUNC_SET_8BIT_2LINE, sel: W_LONG},
    '{data: FUNC_SET_8BIT_2LINE, sel: W_SHORT},
    '{data: FUNC_SET_8BIT_2LINE, sel: W_EXEC},
    '{data: FUNC_SET_8BIT_2LINE, sel: W_EXEC},
    '{data: DISP_ON,             sel: W_EXEC},
    '{data: CMD_CLEAR,           sel: W_CLEAR},
    '{data: ENTRY_INC,           sel: W_EXEC}
  };

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_write_strobe.sv
// Times one LCD bus write: setup, enable pulse, hold and execution wait.
// done is high during the last wait cycle so the caller can move on at that edge.
module lcd_write_strobe
  import lcd_pkg::*;
#(
  parameter int SETUP_CYC   = 4,
  parameter int EN_HIGH_CYC = 25,
  parameter int HOLD_CYC    = 2,
  parameter int CNT_W       = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             short_setup,
  input  logic [CNT_W-1:0] wait_cyc,
  output logic             en,
  output logic             done
);

  state_t           phase;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] wait_q;

  // short_setup: the caller already presented data one cycle before go,
  // so that cycle counts toward the setup time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      phase  <= IDLE;
      cnt    <= '0;
      wait_q <= '0;
      en     <= 1'b0;
    end else begin
      case (phase)
        IDLE: begin
          if (go) begin
            wait_q <= wait_cyc;
            if (short_setup && SETUP_CYC == 1) begin
              phase <= PULSE;
              en    <= 1'b1;
              cnt   <= CNT_W'(EN_HIGH_CYC - 1);
            end else begin
              phase <= SETUP;
              cnt   <= short_setup ? CNT_W'(SETUP_CYC - 2) : CNT_W'(SETUP_CYC - 1);
            end
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            phase <= PULSE;
            en    <= 1'b1;
            cnt   <= CNT_W'(EN_HIGH_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PULSE: begin
          if (cnt == '0) begin
            phase <= HOLD;
            en    <= 1'b0;
            cnt   <= CNT_W'(HOLD_CYC - 1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        HOLD: begin
          if (cnt == '0) begin
            phase <= WAIT;
            cnt   <= wait_q - 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            phase <= IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          phase <= IDLE;
          en    <= 1'b0;
        end
      endcase
    end
  end

  assign done = (phase == WAIT) && (cnt == '0);

endmodule

// File: rtl/lcd_sequencer.sv
// HD44780 8-bit bus controller: power-up wait, fixed init list, then
// command/character writes from a valid/ready requester. Never reads busy.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 2000000,
  parameter int SETUP_CYC      = 4,
  parameter int EN_HIGH_CYC    = 25,
  parameter int HOLD_CYC       = 2,
  parameter int EXEC_CYC       = 2500,
  parameter int CLEAR_CYC      = 82000,
  parameter int INIT_LONG_CYC  = 205000,
  parameter int INIT_SHORT_CYC = 5000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_rs,
  input  logic [7:0] cmd_data,
  output logic       init_done,
  output logic [7:0] data,
  output logic       rw,
  output logic       rs,
  output logic       en
);

  localparam int MAX_CYC = max_of(max_of(max_of(POWERUP_CYC, CLEAR_CYC),
                                         max_of(INIT_LONG_CYC, INIT_SHORT_CYC)),
                                  max_of(max_of(EXEC_CYC, EN_HIGH_CYC),
                                         max_of(SETUP_CYC, HOLD_CYC)));
  localparam int CNT_W = $clog2(MAX_CYC) + 1;
  localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERUP_CYC - 1);
  localparam logic [2:0]       LAST_IDX = 3'(INIT_STEPS - 1);

  state_t           state;
  logic [2:0]       idx;
  logic [CNT_W-1:0] pwr_cnt;
  logic             accept;
  logic             go;
  logic             wr_done;
  logic [CNT_W-1:0] wait_cyc;

  assign rw     = 1'b0;
  assign accept = (state == IDLE) && cmd_valid && cmd_ready && !start;
  assign go     = (state == INIT_LOAD) || accept;

  always_comb begin
    wait_cyc = CNT_W'(EXEC_CYC);
    if (state == INIT_LOAD) begin
      case (INIT_ROM[idx].sel)
        W_CLEAR: wait_cyc = CNT_W'(CLEAR_CYC);
        W_LONG:  wait_cyc = CNT_W'(INIT_LONG_CYC);
        W_SHORT: wait_cyc = CNT_W'(INIT_SHORT_CYC);
        default: wait_cyc = CNT_W'(EXEC_CYC);
      endcase
    end else if (!cmd_rs && (cmd_data inside {CMD_CLEAR, CMD_HOME, CMD_HOME_ALT})) begin
      wait_cyc = CNT_W'(CLEAR_CYC);
    end
  end

  // Bus data/rs are loaded on entry to INIT_LOAD or on acceptance; SETUP here
  // stands for "a write is in flight", its sub-phases live in the strobe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= PWR_WAIT;
      pwr_cnt   <= '0;
      idx       <= '0;
      data      <= '0;
      rs        <= 1'b0;
      cmd_ready <= 1'b0;
      init_done <= 1'b0;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (pwr_cnt == PWR_LAST) begin
            state <= INIT_LOAD;
            idx   <= '0;
            data  <= INIT_ROM[0].data;
            rs    <= 1'b0;
          end else begin
            pwr_cnt <= pwr_cnt + 1'b1;
          end
        end
        INIT_LOAD: begin
          state <= SETUP;
        end
        SETUP: begin
          if (wr_done) begin
            if (init_done) begin
              state     <= IDLE;
              cmd_ready <= 1'b1;
            end else if (idx == LAST_IDX) begin
              state     <= IDLE;
              init_done <= 1'b1;
              cmd_ready <= 1'b1;
            end else begin
              state <= INIT_LOAD;
              idx   <= idx + 3'd1;
              data  <= INIT_ROM[idx + 3'd1].data;
              rs    <= 1'b0;
            end
          end
        end
        IDLE: begin
          if (start) begin
            state     <= INIT_LOAD;
            init_done <= 1'b0;
            cmd_ready <= 1'b0;
            idx       <= '0;
            data      <= INIT_ROM[0].data;
            rs        <= 1'b0;
          end else if (accept) begin
            state     <= SETUP;
            data      <= cmd_data;
            rs        <= cmd_rs;
            cmd_ready <= 1'b0;
          end else begin
            cmd_ready <= init_done;
          end
        end
        default: begin
          state <= PWR_WAIT;
        end
      endcase
    end
  end

  lcd_write_strobe #(
    .SETUP_CYC  (SETUP_CYC),
    .EN_HIGH_CYC(EN_HIGH_CYC),
    .HOLD_CYC   (HOLD_CYC),
    .CNT_W      (CNT_W)
  ) u_strobe (
    .clk        (clk),
    .rst        (rst),
    .go         (go),
    .short_setup(state == INIT_LOAD),
    .wait_cyc   (wait_cyc),
    .en         (en),
    .done       (wr_done)
  );

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer: stimulus pushes expected en pulses and
// cmd_ready return cycles; a negedge monitor pops and compares them.
module tb_lcd_sequencer;

  localparam int EN_HIGH = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic       cmd_rs = 1'b0;
  logic [7:0] cmd_data = 8'h00;
  logic       init_done;
  logic [7:0] data;
  logic       rw;
  logic       rs;
  logic       en;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    logic [7:0] d;
    logic       r;
    int         c;
  } pulse_t;

  pulse_t pq[$];
  int     rq[$];

  // Hand-derived init schedule: rise offsets from the first rise, gap = wait + 6.
  int         init_off [7] = '{0, 14, 26, 37, 48, 59, 75};
  logic [7:0] init_dat [7] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
  localparam int INIT_READY_OFF = 84;

  lcd_sequencer #(
    .POWERUP_CYC   (20),
    .SETUP_CYC     (2),
    .EN_HIGH_CYC   (EN_HIGH),
    .HOLD_CYC      (1),
    .EXEC_CYC      (5),
    .CLEAR_CYC     (10),
    .INIT_LONG_CYC (8),
    .INIT_SHORT_CYC(6)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_rs   (cmd_rs),
    .cmd_data (cmd_data),
    .init_done(init_done),
    .data     (data),
    .rw       (rw),
    .rs       (rs),
    .en       (en)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_init(input int r0);
    pulse_t p;
    for (int i = 0; i < 7; i++) begin
      p.d = init_dat[i];
      p.r = 1'b0;
      p.c = r0 + init_off[i];
      pq.push_back(p);
    end
    rq.push_back(r0 + INIT_READY_OFF);
  endtask

  task automatic do_write(input logic r, input logic [7:0] d, input int lat,
                          input bit keep, input bit want_ready, output int acc);
    pulse_t p;
    int n;
    n = 0;
    acc = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (cmd_ready !== 1'b1) begin
      check("ready_timeout", 0, 1);
      return;
    end
    cmd_rs    = r;
    cmd_data  = d;
    cmd_valid = 1'b1;
    acc = cyc + 1;
    p.d = d;
    p.r = r;
    p.c = acc + 2;
    pq.push_back(p);
    if (want_ready) rq.push_back(acc + lat);
    @(negedge clk);
    if (!keep) cmd_valid = 1'b0;
  endtask

  // Monitor
  logic       prev_en  = 1'b0;
  logic       prev_rdy = 1'b0;
  int         rise_cyc = 0;
  logic [7:0] pdata    = 8'h00;
  logic       prs      = 1'b0;
  logic       stable   = 1'b1;
  pulse_t     mp;
  int         mr;

  always @(negedge clk) begin
    if (!rst) begin
      prev_en  = 1'b0;
      prev_rdy = 1'b0;
    end else begin
      if (en && !prev_en) begin
        if (pq.size() == 0) begin
          check("unexpected_pulse", 1, 0);
        end else begin
          mp = pq.pop_front();
          check("pulse_rise_cycle", cyc, mp.c);
          check("pulse_data", int'(data), int'(mp.d));
          check("pulse_rs", int'(rs), int'(mp.r));
        end
        rise_cyc = cyc;
        pdata    = data;
        prs      = rs;
        stable   = 1'b1;
      end else if (en && (data !== pdata || rs !== prs)) begin
        stable = 1'b0;
      end
      if (!en && prev_en) begin
        check("pulse_width", cyc - rise_cyc, EN_HIGH);
        check("bus_stable_in_pulse", int'(stable && data === pdata && rs === prs), 1);
      end
      if (cmd_ready && !prev_rdy) begin
        if (rq.size() == 0) begin
          check("unexpected_ready", 1, 0);
        end else begin
          mr = rq.pop_front();
          check("ready_cycle", cyc, mr);
          check("ready_init_done", int'(init_done), 1);
        end
      end
      prev_en  = en;
      prev_rdy = cmd_ready;
    end
  end

  initial begin
    int acc;
    int s;
    int n;

    // reset state
    #1;
    check("rst_en", int'(en), 0);
    check("rst_data", int'(data), 0);
    check("rst_rs", int'(rs), 0);
    check("rst_rw", int'(rw), 0);
    check("rst_ready", int'(cmd_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_init(cyc + 22);

    // character and command writes
    do_write(1'b1, 8'h41, 11, 1'b0, 1'b1, acc);
    do_write(1'b0, 8'h01, 16, 1'b0, 1'b1, acc);
    do_write(1'b1, 8'h01, 11, 1'b0, 1'b1, acc);
    do_write(1'b0, 8'h02, 16, 1'b0, 1'b1, acc);
    do_write(1'b0, 8'h03, 16, 1'b0, 1'b1, acc);
    do_write(1'b0, 8'h04, 11, 1'b0, 1'b1, acc);
    check("rw_const", int'(rw), 0);

    // start wins over a simultaneous write
    @(negedge clk);
    n = 0;
    while (cmd_ready !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("start_ready_seen", int'(cmd_ready), 1);
    start     = 1'b1;
    cmd_valid = 1'b1;
    cmd_rs    = 1'b1;
    cmd_data  = 8'h48;
    s = cyc + 1;
    push_init(s + 2);
    begin
      pulse_t p;
      p.d = 8'h48;
      p.r = 1'b1;
      p.c = s + 89;
      pq.push_back(p);
    end
    rq.push_back(s + 98);
    @(negedge clk);
    start = 1'b0;
    check("start_init_done_clr", int'(init_done), 0);
    check("start_ready_clr", int'(cmd_ready), 0);
    while (cyc < s + 87) @(negedge clk);
    cmd_valid = 1'b0;

    // back-to-back with cmd_valid held
    do_write(1'b1, 8'h61, 11, 1'b1, 1'b1, acc);
    do_write(1'b1, 8'h62, 11, 1'b1, 1'b1, acc);
    do_write(1'b0, 8'h01, 16, 1'b0, 1'b1, acc);

    // asynchronous reset in the middle of an enable pulse
    do_write(1'b1, 8'h55, 11, 1'b0, 1'b0, acc);
    while (cyc < acc + 3) @(negedge clk);
    check("pre_reset_en_high", int'(en), 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_en", int'(en), 0);
    check("mid_rst_data", int'(data), 0);
    check("mid_rst_rs", int'(rs), 0);
    check("mid_rst_ready", int'(cmd_ready), 0);
    check("mid_rst_init_done", int'(init_done), 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    push_init(cyc + 22);

    n = 0;
    while ((pq.size() != 0 || rq.size() != 0) && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (20) @(negedge clk);
    check("pulse_queue_empty", pq.size(), 0);
    check("ready_queue_empty", rq.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
HD44780-compatible character-LCD controller driving the 8-bit parallel LCD bus (data, rs, rw, en) on the DE10-Standard GHRD.
- After reset: waits the power-up time, then runs a fixed 7-step initialisation sequence.
- Then accepts command/character writes from a fabric requester over a valid/ready handshake.
- Generates setup, enable-pulse, hold and execution-wait timing for every bus write.
- Write-only: the busy flag is never read.

Parameters:
POWERUP_CYC, 2000000, cycles from reset release to the first init write (40 ms at 50 MHz)
SETUP_CYC, 4, cycles rs/data are stable before en rises
EN_HIGH_CYC, 25, en high width in cycles
HOLD_CYC, 2, cycles rs/data are held after en falls
EXEC_CYC, 2500, post-write wait for normal commands and characters (50 us)
CLEAR_CYC, 82000, post-write wait for clear (0x01) and home (0x02, 0x03) with rs=0
INIT_LONG_CYC, 205000, wait after init step 0 (4.1 ms)
INIT_SHORT_CYC, 5000, wait after init step 1 (100 us)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse that requests re-initialisation
cmd_valid  in  1  requester has a write pending
cmd_ready  out  1  controller accepts a write this cycle
cmd_rs  in  1  0 = command, 1 = character data
cmd_data  in  8  byte to write
init_done  out  1  initialisation complete
data  out  8  LCD DB[7:0]
rw  out  1  LCD R/W, constant 0
rs  out  1  LCD register select
en  out  1  LCD enable strobe

Behaviour:
- rst is asynchronous and active-low. While rst=0, all state clears immediately: data=0, rs=0, rw=0, en=0, cmd_ready=0, init_done=0, state=PWR_WAIT, counter=0. Asserting rst in mid-pulse drops en in the same instant.
- States: PWR_WAIT, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
- A single down-counter is shared by all states. Its width is $clog2 of the largest cycle parameter plus 1.
- PWR_WAIT: count POWERUP_CYC cycles, then go to INIT_LOAD with init index 0.
- INIT_LOAD: drive rs=0 and data=INIT_ROM[idx], select that step's wait, go to SETUP.
- INIT_ROM entries (data, wait):
  - 0: 0x38, INIT_LONG
  - 1: 0x38, INIT_SHORT
  - 2: 0x38, EXEC
  - 3: 0x38, EXEC
  - 4: 0x0C, EXEC
  - 5: 0x01, CLEAR
  - 6: 0x06, EXEC
- Write sequence:
  - SETUP: SETUP_CYC cycles, en=0.
  - PULSE: EN_HIGH_CYC cycles, en=1.
  - HOLD: HOLD_CYC cycles, en=0, data/rs unchanged.
  - WAIT: the selected wait count of cycles, en=0, data/rs unchanged.
- WAIT exit during init: if idx<6, increment idx and go to INIT_LOAD. If idx=6, set init_done=1 and go to IDLE.
- WAIT exit during a user write: go to IDLE.
- IDLE: cmd_ready=1 only when init_done=1. On the edge where cmd_valid and cmd_ready are both high, latch cmd_rs/cmd_data onto rs/data and go to SETUP. cmd_ready is 0 from the next cycle.
- Wait selection for user writes: CLEAR_CYC when cmd_rs=0 and cmd_data is 0x01, 0x02 or 0x03; otherwise EXEC_CYC.
- Latency: cmd_ready reasserts exactly SETUP_CYC+EN_HIGH_CYC+HOLD_CYC+wait cycles after the acceptance edge. en rises SETUP_CYC cycles after acceptance.
- start, when sampled high in IDLE: clear init_done, drop cmd_ready, set idx=0, go to INIT_LOAD (power-up wait skipped).
  - start has priority over a simultaneous cmd_valid; that write is not accepted.
  - start in any other state is ignored and is not queued.
- cmd_valid outside IDLE is ignored. The requester must hold cmd_valid/cmd_rs/cmd_data until the transfer completes.
- rw is constant 0. data/rs change only in INIT_LOAD and on acceptance; they are never changed while en=1.

Decomposition:
- Shared package lcd_pkg holds:
  - state enum
  - INIT_ROM constant array with its wait-select enum (W_EXEC, W_CLEAR, W_LONG, W_SHORT)
  - command constants CMD_CLEAR=0x01, CMD_HOME=0x02, FUNC_SET_8BIT_2LINE=0x38, DISP_ON=0x0C, ENTRY_INC=0x06
- One natural sub-module, lcd_write_strobe:
  - given go, rs, data and wait count, performs SETUP/PULSE/HOLD/WAIT and returns a done pulse
  - lcd_sequencer keeps only the init/IDLE/arbitration FSM

Test Plan:
Bench parameters: POWERUP=20, SETUP=2, EN_HIGH=3, HOLD=1, EXEC=5, CLEAR=10, LONG=8, SHORT=6.
1. Reset release -> en stays 0 for 20 cycles, then 7 en pulses each 3 cycles wide with data 38,38,38,38,0C,01,06 and rs=0. init_done rises after the last wait. Gap from each en fall to the next en rise: 1+LONG+2, 1+SHORT+2, 1+EXEC+2, 1+EXEC+2, 1+EXEC+2, 1+CLEAR+2 cycles.
2. In IDLE, cmd_valid with rs=1, data=0x41 -> en high on cycles 3-5 after acceptance with data=0x41, rs=1. cmd_ready returns at cycle 11.
3. Command 0x01 with rs=0 -> cmd_ready returns 16 cycles after acceptance. Character 0x01 with rs=1 -> 11 cycles.
4. start and cmd_valid high together in IDLE -> write not accepted, init_done=0, full 7-step sequence with no power-up wait, then the held write is accepted.
5. rst driven low during PULSE -> en, data, rs, cmd_ready, init_done all 0 asynchronously. After release, the power-up wait restarts from 20.
6. Back-to-back writes with cmd_valid held high -> every write gets the full SETUP+EN+HOLD+WAIT spacing and en never overlaps a data change.
